mem_wb_sender: RTL

MEM_WB_SENDER -- requirements
Module: mem_wb_sender

---
 rtl/mem_wb_sender.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_wb_sender.sv
// mem_wb_sender: MEM stage holding one EXE instruction, waiting for its data response,
// formatting load results and dropping responses still owed to flushed requests.
module mem_wb_sender (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_valid,
    output logic        mem_allowin,
    input  logic [75:0] exe_bus,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        wb_allowin,
    output logic        mem_to_wb_valid,
    output logic [70:0] mem_to_wb_bus,
    input  logic        exec_flush,
    output logic [38:0] mem_fwd_bus
);
    logic        mem_valid_q;
    logic        data_got_q;
    logic [75:0] bus_q;
    logic [31:0] rdata_buf_q;
    logic [1:0]  discard_cnt_q;
    logic [1:0]  discard_cnt_d;
    logic        ex, gr_we, is_load, req_sent;
    logic [31:0] pc, result;
    logic [4:0]  dest;
    logic [2:0]  ld_op;
    logic        drop, capture, got, mem_ready_go, accept;
    logic [31:0] word, load_res, final_result;
    logic [7:0]  b;
    logic [15:0] h;
    logic [2:0]  cnt_sum;

    assign {ex, pc, gr_we, dest, result, is_load, ld_op, req_sent} = bus_q;

    // Any response arriving while debts are outstanding belongs to a flushed request.
    assign drop         = data_data_ok & (discard_cnt_q != 2'd0);
    assign capture      = data_data_ok & ~drop & mem_valid_q & req_sent & ~data_got_q;
    assign got          = data_got_q | capture;
    assign mem_ready_go = ~(req_sent & ~ex & ~got);
    assign mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid_q & mem_ready_go;
    assign accept       = mem_allowin & exe_valid;

    assign word = data_got_q ? rdata_buf_q : data_rdata;
    assign b    = result[1] ? (result[0] ? word[31:24] : word[23:16])
                            : (result[0] ? word[15:8]  : word[7:0]);
    assign h    = result[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_res = word;
        case (ld_op)
            3'b001:  load_res = {{24{b[7]}}, b};
            3'b011:  load_res = {24'd0, b};
            3'b010:  load_res = {{16{h[15]}}, h};
            3'b100:  load_res = {16'd0, h};
            default: load_res = word;
        endcase
    end

    assign final_result  = is_load ? load_res : result;
    assign mem_to_wb_bus = {ex, pc, gr_we, dest, final_result};
    assign mem_fwd_bus   = {mem_valid_q & gr_we, dest, final_result,
                            mem_valid_q & is_load & ~mem_ready_go};

    // A response captured in the flush cycle is no longer owed, hence ~got rather than ~data_got_q.
    assign cnt_sum = {1'b0, discard_cnt_q}
                   + (exec_flush ? 3'(mem_valid_q & req_sent & ~got) + 3'(exe_valid & exe_bus[0]) : 3'd0)
                   - {2'b00, drop};
    assign discard_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q   <= 1'b0;
            data_got_q    <= 1'b0;
            bus_q         <= '0;
            rdata_buf_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            mem_valid_q   <= exec_flush ? 1'b0 : (mem_allowin ? exe_valid : mem_valid_q);
            discard_cnt_q <= discard_cnt_d;
            if (accept) bus_q <= exe_bus;
            if (capture) rdata_buf_q <= data_rdata;
            if (exec_flush | accept) data_got_q <= 1'b0;
            else if (capture) data_got_q <= 1'b1;
        end
    end
endmodule
